rename_dispatch: RTL and testbench
==================================

// Module: rename_dispatch
// PURPOSE
//  Stage directly upstream of the Issue reservation stations.
//  Keeps the register-status table (per arch reg: busy + producer tag) and the free list of 3-bit tags.
//  Resolves each decoded instruction's operands to value or tag and drives the Issue inputs (id, P*/Q*, srcA/scrB/StoreData, valid_instruction).
//  Snoops both CDBs to retire tags and produce register-file writeback.
// PARAMETERS
//  NUM_TAGS  8   in-flight tags; must equal 2**TAG_W
//  TAG_W     3   tag width; matches Issue id/Q width
//  NUM_REGS  32  architectural registers; r0 is hard-wired zero
//  DATA_W    32  operand width
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        asynchronous, active-low reset
//  dec_valid        in   1        decoded instruction present
//  dec_rs/rt/rd     in   5 each   source/base, source/store-data, destination
//  dec_reg_write    in   1        instruction writes dec_rd
//  dec_alu_src      in   1        1: scrB = dec_imm, else rt operand
//  dec_mem_write    in   1        sw: rt is store data
//  dec_imm          in   DATA_W   sign-extended immediate
//  rf_rs_data       in   DATA_W   RF read of dec_rs (async RF)
//  rf_rt_data       in   DATA_W   RF read of dec_rt
//  issue_full       in   1        back-pressure from Issue
//  mem/int_CDB_valid in  1 each   CDB broadcasts
//  mem/int_CDB_id   in   TAG_W    producer tags
//  mem/int_CDB_value in  DATA_W   results
//  valid_instruction out 1        to Issue: dispatch fires this cycle
//  id               out  TAG_W    allocated tag
//  Pj,Qj,srcA       out  1,TAG_W,DATA_W  rs operand
//  Pk,Qk,scrB       out  1,TAG_W,DATA_W  rt/imm operand
//  Pi,Qi,StoreData  out  1,TAG_W,DATA_W  sw store data
//  dec_stall        out  1        to fetch/decode: hold instruction
//  wb_int_we/wb_mem_we out 1 each RF write enables
//  wb_int_addr/wb_mem_addr out 5 each   RF write addresses
//  wb_int_data/wb_mem_data out DATA_W   RF write data
// BEHAVIOUR
//  - Reset (rst=0, async): all status entries not-busy, free mask all ones, every output 0.
//  - fire = dec_valid & ~issue_full & |free. Outputs are combinational and held valid while fire=1; Issue samples them at the same posedge.
//  - valid_instruction = fire; dec_stall = dec_valid & ~fire.
//  - Allocation: every fired instruction (incl. sw/branch) takes the lowest-index free tag; id = that tag; bit cleared at the posedge.
//  - Operand resolve, per source reg s:
//    - s==0 or not busy: P=0, value from RF.
//    - Busy with tag T and a CDB with id==T valid this cycle: P=0, value = CDB value (bypass); int CDB is checked before mem CDB.
//    - Otherwise P=1, Q=T, value=0.
//  - scrB = dec_imm with Pk=0 when dec_alu_src=1.
//  - Pi/Qi/StoreData are resolved from rt only when dec_mem_write=1; otherwise all 0.
//  - Sources read status before this instruction's own dest update (rs==rd reads the old mapping).
//  - Dest update: on fire & dec_reg_write & rd!=0, status[rd] <= {busy=1, tag=id}.
//  - CDB retire, each valid bus:
//    - Free bit for id is set at the posedge; usable from the next cycle, never same-cycle.
//    - Every reg whose status tag==id is cleared, unless that reg is being newly allocated this cycle (new allocation wins).
//    - wb_*_we=1, addr = such reg, data = CDB value. WAW gives no write if no reg still maps the tag.
//  - Both CDBs in one cycle: handled independently; ids are guaranteed distinct.
//  - Free list empty: no fire, no state change except CDB retire.
//  - Tag already free when its CDB arrives: protocol violation; assertion fires.
// STRUCTURE
//  - Shared package tomasulo_pkg holds TAG_W, NUM_TAGS, tag_t, the lw/sw opcode constants, and status_entry_t {busy, tag}.
//  - Sub-module tag_free_list (bitmap, priority-encode allocate, two release ports, empty flag).
//  - Status table and operand-resolve muxing stay in this module.
// TESTING
//  1. Reset, then add r3,r1,r2 with r1=5, r2=7
//     -> id=0, Pj=Pk=0, srcA=5, scrB=7.
//     Next add r4,r3,r3 -> id=1, Pj=Pk=1, Qj=Qk=0.
//  2. Consumer of r3 (tag 0) dispatched in the same cycle as int_CDB{1,id 0,0x55}
//     -> Pj=0, srcA=0x55, wb_int_we=1, addr=3, data=0x55; status[r3] clears.
//  3. Eight writing dispatches with no CDB -> 9th: dec_stall=1, valid_instruction=0.
//     mem_CDB id=2 -> following cycle dispatch gets id=2.
//  4. sw r5,4(r6), r5 busy tag 3, r6 ready=0x100
//     -> Pi=1, Qi=3, Pj=0, srcA=0x100, scrB=4; no status write; tag allocated.
//  5. Two writes to r7 (tags 0,1); int_CDB id 0 -> r7 busy with tag 1.
//     mem_CDB id 1 -> r7 cleared, wb_mem addr=7.
//  6. Assert rst low mid-stream with issue_full=1 -> outputs 0 immediately.
//     After release, first dispatch gets id=0.

Source files
------------

// File: rtl/rename_dispatch_pkg.sv
// rename_dispatch_pkg: shared Tomasulo tag/register types and operand-resolve helper
package rename_dispatch_pkg;
   localparam int TAG_W = 3;
   localparam int NUM_TAGS = 2 ** TAG_W;
   localparam int NUM_REGS = 32;
   localparam int REG_W = 5;
   localparam int DATA_W = 32;
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2b;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [REG_W-1:0] reg_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef struct packed { logic busy; tag_t tag; } status_entry_t;
   typedef struct packed { logic valid; tag_t id; data_t value; } cdb_t;
   typedef struct packed { logic p; tag_t q; data_t v; } operand_t;
   function automatic logic [NUM_TAGS-1:0] tag_onehot(input logic v, input tag_t t);
      return NUM_TAGS'(v) << t;
   endfunction
   // int CDB wins over mem CDB when bypassing a pending producer
   function automatic operand_t resolve(input status_entry_t e, input logic zero, input data_t rf,
                                        input cdb_t ic, input cdb_t mc);
      if (zero || !e.busy) return '{1'b0, tag_t'(0), rf};
      if (ic.valid && ic.id == e.tag) return '{1'b0, tag_t'(0), ic.value};
      if (mc.valid && mc.id == e.tag) return '{1'b0, tag_t'(0), mc.value};
      return '{1'b1, e.tag, data_t'(0)};
   endfunction
endpackage

// File: rtl/rename_dispatch_if.sv
// rename_dispatch_if: decode, RF, CDB, Issue and writeback signals of the rename stage
interface rename_dispatch_if;
   import rename_dispatch_pkg::*;
   logic dec_valid, dec_reg_write, dec_alu_src, dec_mem_write, issue_full;
   reg_t dec_rs, dec_rt, dec_rd;
   data_t dec_imm, rf_rs_data, rf_rt_data;
   logic mem_CDB_valid, int_CDB_valid;
   tag_t mem_CDB_id, int_CDB_id;
   data_t mem_CDB_value, int_CDB_value;
   logic valid_instruction, Pj, Pk, Pi, dec_stall;
   tag_t id, Qj, Qk, Qi;
   data_t srcA, scrB, StoreData;
   logic wb_int_we, wb_mem_we;
   reg_t wb_int_addr, wb_mem_addr;
   data_t wb_int_data, wb_mem_data;
   modport master(
      output dec_valid, dec_rs, dec_rt, dec_rd, dec_reg_write, dec_alu_src, dec_mem_write, dec_imm,
             rf_rs_data, rf_rt_data, issue_full, mem_CDB_valid, mem_CDB_id, mem_CDB_value,
             int_CDB_valid, int_CDB_id, int_CDB_value,
      input  valid_instruction, id, Pj, Qj, srcA, Pk, Qk, scrB, Pi, Qi, StoreData, dec_stall,
             wb_int_we, wb_int_addr, wb_int_data, wb_mem_we, wb_mem_addr, wb_mem_data);
   modport slave(
      input  dec_valid, dec_rs, dec_rt, dec_rd, dec_reg_write, dec_alu_src, dec_mem_write, dec_imm,
             rf_rs_data, rf_rt_data, issue_full, mem_CDB_valid, mem_CDB_id, mem_CDB_value,
             int_CDB_valid, int_CDB_id, int_CDB_value,
      output valid_instruction, id, Pj, Qj, srcA, Pk, Qk, scrB, Pi, Qi, StoreData, dec_stall,
             wb_int_we, wb_int_addr, wb_int_data, wb_mem_we, wb_mem_addr, wb_mem_data);
endinterface

// File: rtl/rename_dispatch_tag_free_list.sv
// tag_free_list: bitmap of free tags, lowest-index allocate, two release ports
module tag_free_list
   import rename_dispatch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic alloc,
   input  logic rel0_valid,
   input  tag_t rel0_tag,
   input  logic rel1_valid,
   input  tag_t rel1_tag,
   output tag_t alloc_tag,
   output logic empty
);
   logic [NUM_TAGS-1:0] free;
   always_comb begin
      alloc_tag = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) if (free[i]) alloc_tag = tag_t'(i);
   end
   assign empty = ~|free;
   // released tags become allocatable only from the following cycle
   always_ff @(posedge clk or negedge rst)
      if (!rst) free <= '1;
      else begin
         assert (!(rel0_valid && free[rel0_tag])) else $error("tag %0d released while already free", rel0_tag);
         assert (!(rel1_valid && free[rel1_tag])) else $error("tag %0d released while already free", rel1_tag);
         free <= (free & ~tag_onehot(alloc, alloc_tag)) | tag_onehot(rel0_valid, rel0_tag) | tag_onehot(rel1_valid, rel1_tag);
      end
endmodule

// File: rtl/rename_dispatch.sv
// rename_dispatch: register-status table, tag allocation and operand resolve feeding Issue
module rename_dispatch
   import rename_dispatch_pkg::*;
(
   input logic clk,
   input logic rst,
   rename_dispatch_if.slave bus
);
   status_entry_t status [NUM_REGS];
   tag_t alloc_tag;
   logic empty, fire, alloc_rd;
   cdb_t ic, mc;
   operand_t rs_op, rt_op;
   logic [NUM_REGS-1:0] int_hit, mem_hit;
   reg_t int_addr, mem_addr;
   assign ic = '{bus.int_CDB_valid, bus.int_CDB_id, bus.int_CDB_value};
   assign mc = '{bus.mem_CDB_valid, bus.mem_CDB_id, bus.mem_CDB_value};
   assign fire = rst & bus.dec_valid & ~bus.issue_full & ~empty;
   assign alloc_rd = fire & bus.dec_reg_write & (bus.dec_rd != '0);
   assign rs_op = resolve(status[bus.dec_rs], bus.dec_rs == '0, bus.rf_rs_data, ic, mc);
   assign rt_op = resolve(status[bus.dec_rt], bus.dec_rt == '0, bus.rf_rt_data, ic, mc);
   assign bus.valid_instruction = fire;
   assign bus.dec_stall = rst & bus.dec_valid & ~fire;
   assign bus.id = fire ? alloc_tag : '0;
   assign bus.Pj = fire & rs_op.p;
   assign bus.Qj = fire ? rs_op.q : '0;
   assign bus.srcA = fire ? rs_op.v : '0;
   assign bus.Pk = fire & ~bus.dec_alu_src & rt_op.p;
   assign bus.Qk = (fire & ~bus.dec_alu_src) ? rt_op.q : '0;
   assign bus.scrB = !fire ? '0 : bus.dec_alu_src ? bus.dec_imm : rt_op.v;
   assign bus.Pi = fire & bus.dec_mem_write & rt_op.p;
   assign bus.Qi = (fire & bus.dec_mem_write) ? rt_op.q : '0;
   assign bus.StoreData = (fire & bus.dec_mem_write) ? rt_op.v : '0;
   // a reg being remapped this cycle keeps its new tag and gets no writeback
   always_comb begin
      int_hit = '0;
      mem_hit = '0;
      int_addr = '0;
      mem_addr = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         int_hit[r] = ic.valid & status[r].busy & (status[r].tag == ic.id) & ~(alloc_rd & (bus.dec_rd == reg_t'(r)));
         mem_hit[r] = mc.valid & status[r].busy & (status[r].tag == mc.id) & ~(alloc_rd & (bus.dec_rd == reg_t'(r)));
         if (int_hit[r]) int_addr = reg_t'(r);
         if (mem_hit[r]) mem_addr = reg_t'(r);
      end
   end
   assign bus.wb_int_we = |int_hit;
   assign bus.wb_int_addr = int_addr;
   assign bus.wb_int_data = |int_hit ? ic.value : '0;
   assign bus.wb_mem_we = |mem_hit;
   assign bus.wb_mem_addr = mem_addr;
   assign bus.wb_mem_data = |mem_hit ? mc.value : '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) for (int r = 0; r < NUM_REGS; r++) status[r] <= '0;
      else
         for (int r = 1; r < NUM_REGS; r++)
            if (alloc_rd && bus.dec_rd == reg_t'(r)) status[r] <= '{1'b1, alloc_tag};
            else if (int_hit[r] || mem_hit[r]) status[r] <= '0;
   tag_free_list u_free (
      .clk(clk),
      .rst(rst),
      .alloc(fire),
      .rel0_valid(ic.valid),
      .rel0_tag(ic.id),
      .rel1_valid(mc.valid),
      .rel1_tag(mc.id),
      .alloc_tag(alloc_tag),
      .empty(empty)
   );
endmodule

// File: tb/tb_rename_dispatch.sv
// tb_rename_dispatch: directed vector table plus hand sequences for rename_dispatch
module tb_rename_dispatch;
   import rename_dispatch_pkg::*;
   typedef struct {
      logic v; logic [4:0] rs, rt, rd; logic rw, alu, mw; logic [31:0] imm, rsd, rtd;
      logic full; logic iv; logic [2:0] iid; logic [31:0] ival; logic mv; logic [2:0] mid; logic [31:0] mval;
   } in_t;
   typedef struct {
      logic vi; logic [2:0] id; logic pj; logic [2:0] qj; logic [31:0] sa;
      logic pk; logic [2:0] qk; logic [31:0] sb; logic pi; logic [2:0] qi; logic [31:0] sd;
      logic stall; logic iwe; logic [4:0] iaddr; logic [31:0] idata; logic mwe; logic [4:0] maddr; logic [31:0] mdata;
   } exp_t;
   typedef struct { in_t i; exp_t e; } vec_t;
   logic clk = 0;
   logic rst = 0;
   int checks = 0;
   int errors = 0;
   rename_dispatch_if bus();
   rename_dispatch dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic apply(input in_t i);
      bus.dec_valid = i.v; bus.dec_rs = i.rs; bus.dec_rt = i.rt; bus.dec_rd = i.rd;
      bus.dec_reg_write = i.rw; bus.dec_alu_src = i.alu; bus.dec_mem_write = i.mw; bus.dec_imm = i.imm;
      bus.rf_rs_data = i.rsd; bus.rf_rt_data = i.rtd; bus.issue_full = i.full;
      bus.int_CDB_valid = i.iv; bus.int_CDB_id = i.iid; bus.int_CDB_value = i.ival;
      bus.mem_CDB_valid = i.mv; bus.mem_CDB_id = i.mid; bus.mem_CDB_value = i.mval;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
      end
   endtask
   task automatic cmp(input string n, input exp_t e);
      chk({n, ".vi"}, 32'(bus.valid_instruction), 32'(e.vi));
      chk({n, ".id"}, 32'(bus.id), 32'(e.id));
      chk({n, ".Pj"}, 32'(bus.Pj), 32'(e.pj));
      chk({n, ".Qj"}, 32'(bus.Qj), 32'(e.qj));
      chk({n, ".srcA"}, bus.srcA, e.sa);
      chk({n, ".Pk"}, 32'(bus.Pk), 32'(e.pk));
      chk({n, ".Qk"}, 32'(bus.Qk), 32'(e.qk));
      chk({n, ".scrB"}, bus.scrB, e.sb);
      chk({n, ".Pi"}, 32'(bus.Pi), 32'(e.pi));
      chk({n, ".Qi"}, 32'(bus.Qi), 32'(e.qi));
      chk({n, ".StoreData"}, bus.StoreData, e.sd);
      chk({n, ".stall"}, 32'(bus.dec_stall), 32'(e.stall));
      chk({n, ".wb_int_we"}, 32'(bus.wb_int_we), 32'(e.iwe));
      chk({n, ".wb_int_addr"}, 32'(bus.wb_int_addr), 32'(e.iaddr));
      chk({n, ".wb_int_data"}, bus.wb_int_data, e.idata);
      chk({n, ".wb_mem_we"}, 32'(bus.wb_mem_we), 32'(e.mwe));
      chk({n, ".wb_mem_addr"}, 32'(bus.wb_mem_addr), 32'(e.maddr));
      chk({n, ".wb_mem_data"}, bus.wb_mem_data, e.mdata);
   endtask
   task automatic step(input in_t i);
      @(posedge clk);
      #1 apply(i);
      @(negedge clk);
   endtask
   function automatic in_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      in_t i;
      i = '{default: '0};
      i.v = 1; i.rs = rs; i.rt = rt; i.rd = rd; i.rw = 1;
      return i;
   endfunction
   task automatic reset_dut();
      in_t z;
      z = '{default: '0};
      @(negedge clk);
      apply(z);
      rst = 0;
      @(negedge clk);
      rst = 1;
   endtask
   vec_t tbl [13];
   initial begin
      in_t idle, x;
      exp_t zero;
      idle = '{default: '0};
      zero = '{default: '0};
      tbl[0]  = '{'{1,1,2,3,1,0,0,0,5,7,0,0,0,0,0,0,0}, '{1,0,0,0,5,0,0,7,0,0,0,0,0,0,0,0,0,0}};
      tbl[1]  = '{'{1,3,3,4,1,0,0,0,'hAA,'hAA,0,0,0,0,0,0,0}, '{1,1,1,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0}};
      tbl[2]  = '{'{1,3,0,8,1,0,0,0,'hAA,0,0,1,0,'h55,0,0,0}, '{1,2,0,0,'h55,0,0,0,0,0,0,0,1,3,'h55,0,0,0}};
      tbl[3]  = '{'{1,3,4,9,1,0,0,0,'h55,'hAA,0,0,0,0,0,0,0}, '{1,0,0,0,'h55,1,1,0,0,0,0,0,0,0,0,0,0,0}};
      tbl[4]  = '{'{1,1,2,5,1,0,0,0,1,2,0,0,0,0,0,0,0}, '{1,3,0,0,1,0,0,2,0,0,0,0,0,0,0,0,0,0}};
      tbl[5]  = '{'{1,6,5,6,0,1,1,4,'h100,'hDEAD,0,0,0,0,0,0,0}, '{1,4,0,0,'h100,0,0,4,1,3,0,0,0,0,0,0,0,0}};
      tbl[6]  = '{'{1,6,5,11,1,0,0,0,'h100,'hDEAD,0,0,0,0,0,0,0}, '{1,5,0,0,'h100,1,3,0,0,0,0,0,0,0,0,0,0,0}};
      tbl[7]  = '{'{1,5,2,12,1,0,0,0,1,2,1,0,0,0,1,3,'h33}, '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,1,5,'h33}};
      tbl[8]  = '{'{1,5,2,12,1,0,0,0,'h33,9,0,0,0,0,0,0,0}, '{1,3,0,0,'h33,0,0,9,0,0,0,0,0,0,0,0,0,0}};
      tbl[9]  = '{'{1,4,8,13,1,0,0,0,0,0,0,1,1,'h11,1,2,'h22}, '{1,6,0,0,'h11,0,0,'h22,0,0,0,0,1,4,'h11,1,8,'h22}};
      tbl[10] = '{'{0,0,0,0,0,0,0,0,0,0,0,1,0,'h99,0,0,0}, '{0,0,0,0,0,0,0,0,0,0,0,0,1,9,'h99,0,0,0}};
      tbl[11] = '{'{1,0,0,12,1,0,0,0,0,0,0,1,3,'h12,0,0,0}, '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
      tbl[12] = '{'{1,12,0,14,1,0,0,0,'h12,0,0,0,0,0,0,0,0}, '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
      x = add(1, 2, 3);
      x.rsd = 5; x.rtd = 7;
      apply(x);
      repeat (2) @(negedge clk);
      cmp("reset", zero);
      apply(idle);
      rst = 1;
      for (int k = 0; k < 13; k++) begin
         step(tbl[k].i);
         cmp($sformatf("v%0d", k), tbl[k].e);
      end
      // free list exhaustion and tag recycling
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         step(add(0, 0, 5'(k + 1)));
         chk($sformatf("t3.id%0d", k), 32'(bus.id), k);
      end
      step(add(0, 0, 9));
      chk("t3.full_stall", 32'(bus.dec_stall), 1);
      chk("t3.full_vi", 32'(bus.valid_instruction), 0);
      x = add(0, 0, 9);
      x.mv = 1; x.mid = 2; x.mval = 'h22;
      step(x);
      chk("t3.same_cycle_stall", 32'(bus.dec_stall), 1);
      chk("t3.wb_mem_addr", 32'(bus.wb_mem_addr), 3);
      step(add(0, 0, 10));
      chk("t3.recycled_vi", 32'(bus.valid_instruction), 1);
      chk("t3.recycled_id", 32'(bus.id), 2);
      // WAW on r7
      reset_dut();
      step(add(0, 0, 7));
      chk("t5.id0", 32'(bus.id), 0);
      step(add(0, 0, 7));
      chk("t5.id1", 32'(bus.id), 1);
      x = idle;
      x.iv = 1; x.iid = 0; x.ival = 'h70;
      step(x);
      chk("t5.stale_we", 32'(bus.wb_int_we), 0);
      step(add(7, 0, 20));
      chk("t5.Pj", 32'(bus.Pj), 1);
      chk("t5.Qj", 32'(bus.Qj), 1);
      chk("t5.id_reuse", 32'(bus.id), 0);
      x = idle;
      x.mv = 1; x.mid = 1; x.mval = 'h71;
      step(x);
      chk("t5.wb_mem_we", 32'(bus.wb_mem_we), 1);
      chk("t5.wb_mem_addr", 32'(bus.wb_mem_addr), 7);
      chk("t5.wb_mem_data", bus.wb_mem_data, 'h71);
      x = add(7, 0, 21);
      x.rsd = 'h71;
      step(x);
      chk("t5.cleared_Pj", 32'(bus.Pj), 0);
      chk("t5.cleared_srcA", bus.srcA, 'h71);
      // asynchronous reset mid-stream
      x = add(1, 0, 22);
      x.rsd = 5; x.full = 1; x.iv = 1; x.iid = 0; x.ival = 'h20;
      step(x);
      chk("t6.pre_stall", 32'(bus.dec_stall), 1);
      chk("t6.pre_we", 32'(bus.wb_int_we), 1);
      chk("t6.pre_addr", 32'(bus.wb_int_addr), 20);
      #2 rst = 0;
      #1;
      chk("t6.rst_stall", 32'(bus.dec_stall), 0);
      chk("t6.rst_we", 32'(bus.wb_int_we), 0);
      chk("t6.rst_addr", 32'(bus.wb_int_addr), 0);
      chk("t6.rst_data", bus.wb_int_data, 0);
      chk("t6.rst_vi", 32'(bus.valid_instruction), 0);
      @(negedge clk);
      apply(idle);
      @(negedge clk);
      rst = 1;
      x = add(1, 2, 3);
      x.rsd = 5; x.rtd = 6;
      step(x);
      chk("t6.post_vi", 32'(bus.valid_instruction), 1);
      chk("t6.post_id", 32'(bus.id), 0);
      chk("t6.post_srcA", bus.srcA, 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
